// File: rtl/game_ctrl.sv
// Snake game sequencer: IDLE/PLAY/OVER, frame-paced moves, score; PAUSE state only with GAME_CTRL_PAUSE_EN.
// All outputs registered with 1-clk latency; no backpressure, snake_init/move_tick are single-cycle pulses.
module game_ctrl #(
    parameter int STEP_FRAMES      = 8,
    parameter int OVER_HOLD_FRAMES = 120,
    parameter int SCORE_W          = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync_in,
    input  logic               start_btn,
    input  logic               head_hit_frame,
    input  logic               head_hit_tail,
    input  logic               food_eaten,
    output logic [1:0]         state,
    output logic               snake_init,
    output logic               move_tick,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PLAY  = 2'b01,
        S_OVER  = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);
    localparam logic [7:0] HOLD_MAX  = 8'(OVER_HOLD_FRAMES);

    state_t             state_q, state_d;
    logic               vsync_q, start_q;
    logic               frame_tick, start_edge, collision;
    logic [7:0]         step_q, step_d;
    logic [7:0]         hold_q, hold_d;
    logic [SCORE_W-1:0] score_d;
    logic               init_d, move_d, over_d;

    assign frame_tick = vsync_in & ~vsync_q;
    assign start_edge = start_btn & ~start_q;
    assign collision  = head_hit_frame | head_hit_tail;
    assign state      = state_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        hold_d  = hold_q;
        score_d = score;
        init_d  = 1'b0;
        move_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_PLAY;
                    init_d  = 1'b1;
                    score_d = '0;
                    step_d  = 8'd0;
                end
            end
            S_PLAY: begin
                // Food still counts on the cycle the snake dies.
                if (food_eaten && (score != '1)) begin
                    score_d = score + 1'b1;
                end
                if (collision) begin
                    state_d = S_OVER;
                    hold_d  = 8'd0;
                end else begin
                    if (frame_tick) begin
                        if (step_q == STEP_LAST) begin
                            move_d = 1'b1;
                            step_d = 8'd0;
                        end else begin
                            step_d = step_q + 8'd1;
                        end
                    end
`ifdef GAME_CTRL_PAUSE_EN
                    if (start_edge) begin
                        state_d = S_PAUSE;
                    end
`endif
                end
            end
            S_OVER: begin
                if (frame_tick && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + 8'd1;
                end
                if (start_edge && (hold_q == HOLD_MAX)) begin
                    state_d = S_PLAY;
                    init_d  = 1'b1;
                    score_d = '0;
                    step_d  = 8'd0;
                end
            end
`ifdef GAME_CTRL_PAUSE_EN
            S_PAUSE: begin
                // Step counter stays frozen so the move cadence resumes where it left off.
                if (start_edge) begin
                    state_d = S_PLAY;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vsync_q    <= 1'b1;
            start_q    <= 1'b1;
            step_q     <= 8'd0;
            hold_q     <= 8'd0;
            score      <= '0;
            snake_init <= 1'b0;
            move_tick  <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vsync_q    <= vsync_in;
            start_q    <= start_btn;
            step_q     <= step_d;
            hold_q     <= hold_d;
            score      <= score_d;
            snake_init <= init_d;
            move_tick  <= move_d;
            game_over  <= over_d;
        end
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the snake datapath. It sits beside the frame/collision stage in the VGA pipeline and consumes its per-pixel collision flags, the vsync timing and the start button. It owns the IDLE/PLAY/OVER state, paces snake motion in whole video frames, clears the snake body on each new game and keeps the score.

## Interface
Parameters:
- STEP_FRAMES, 8: frame ticks per snake move; legal range 1..255.
- OVER_HOLD_FRAMES, 120: frame ticks in OVER before start is accepted again; legal range 0..255.
- SCORE_W, 8: score counter width.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset; asynchronous, active-high.
- vsync_in  in  1  vsync from the timing chain; each rising edge is one frame tick.
- start_btn  in  1  start button level, already synchronised and debounced.
- head_hit_frame  in  1  head pixel overlaps the frame border, level.
- head_hit_tail  in  1  head pixel overlaps the snake body, level.
- food_eaten  in  1  one-cycle pulse when the head reaches food.
- state  out  2  game state: 00 IDLE, 01 PLAY, 10 OVER, 11 PAUSE (PAUSE only with the macro).
- snake_init  out  1  one-cycle pulse that resets the snake body/position.
- move_tick  out  1  one-cycle pulse that advances the snake one grid cell.
- score  out  SCORE_W  food count for the current game.
- game_over  out  1  high while state is OVER.

## Operation
- Edge detection:
  - Registers vsync_q and start_q reset to 1, so a signal already high at reset release produces no edge.
  - frame_tick = vsync_in & ~vsync_q.
  - start_edge = start_btn & ~start_q.
- IDLE:
  - start_edge moves to PLAY.
  - On that transition: snake_init pulses, score clears to 0, step counter clears to 0.
- PLAY:
  - Step counter increments on each frame_tick.
  - When the counter equals STEP_FRAMES-1 at a frame_tick: move_tick pulses and the counter wraps to 0.
  - food_eaten increments score; score saturates at all-ones and does not wrap.
  - head_hit_frame | head_hit_tail moves to OVER and clears the hold counter.
- OVER:
  - game_over = 1.
  - Hold counter increments on frame_tick and saturates at OVER_HOLD_FRAMES.
  - start_edge with hold counter == OVER_HOLD_FRAMES moves to PLAY with the same init actions as from IDLE.
  - start_edge before the hold expires is ignored.
  - score is frozen.
- Simultaneous events:
  - Collision in the same cycle as a move_tick condition: enter OVER, suppress move_tick.
  - Collision and food_eaten in the same cycle: score still increments, then enter OVER.
  - Collision and start_edge in PLAY: collision wins.
  - Collision inputs are ignored outside PLAY.
- Reset mid-game: all state is abandoned. The block returns to IDLE with all outputs 0 and issues no snake_init until the next start_edge.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, snake_init=0, move_tick=0, score=0, game_over=0. Internal counters reset to 0.
- Latency from input condition to output change is 1 clk:
  - start_edge to (state=PLAY, snake_init=1) on the same edge; snake_init deasserts on the following clk.
  - Collision to (state=OVER, game_over=1).
  - frame_tick to move_tick.
  - food_eaten to score+1.
- move_tick period is exactly STEP_FRAMES frames.
  - The first move_tick after entering PLAY is STEP_FRAMES frame ticks later.
  - With STEP_FRAMES=1, move_tick fires on every frame tick.
- With OVER_HOLD_FRAMES=0, start is accepted on the first cycle of OVER.

## Configuration
- GAME_CTRL_PAUSE_EN defined:
  - start_edge in PLAY moves to PAUSE (state=11).
  - In PAUSE the step counter is frozen, and move_tick, food_eaten and collisions are ignored.
  - start_edge in PAUSE returns to PLAY; the step counter resumes from its frozen value and there is no snake_init.
- GAME_CTRL_PAUSE_EN undefined:
  - start_edge in PLAY is ignored.
  - State 11 is unreachable.
  - No pause logic is synthesised.

## Test plan
Benches use STEP_FRAMES=4, OVER_HOLD_FRAMES=3, SCORE_W=8.
- Reset with start_btn and vsync_in held high, then release: state stays 00 and no frame_tick occurs; drop and re-raise start_btn -> state=01 and snake_init high for exactly 1 clk.
- In PLAY, 12 vsync rising edges -> exactly 3 move_tick pulses, each 1 clk after the 4th, 8th and 12th edge.
- 5 food_eaten pulses -> score=5; preload score=255, one more pulse -> score stays 255.
- head_hit_tail asserted in the cycle a move_tick is due -> state=10, game_over=1, no move_tick; score unchanged unless food_eaten coincides.
- In OVER: start_edge after 2 frame ticks -> ignored; start_edge after 3 frame ticks -> state=01, snake_init pulse, score=0.
- With GAME_CTRL_PAUSE_EN: start_edge in PLAY -> state=11; 10 vsync edges and a collision -> no move_tick, stays 11; start_edge -> state=01 with step count preserved.
